// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: N-master AXI read arbiter, one read outstanding, R beats routed to the granted master.
// Define AXI_RD_ARB_RR_EN for round-robin grant; otherwise fixed priority with master 0 highest.
module axi_rd_arbiter #(
    parameter int NUM_M  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8,
    parameter int ID_W   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_M*ADDR_W-1:0] m_araddr,
    input  logic [NUM_M*LEN_W-1:0]  m_arlen,
    input  logic [NUM_M*2-1:0]      m_arburst,
    input  logic [NUM_M-1:0]        m_arvalid,
    output logic [NUM_M-1:0]        m_arready,
    output logic [DATA_W-1:0]       m_rdata,
    output logic [NUM_M-1:0]        m_rlast,
    output logic [NUM_M-1:0]        m_rvalid,
    input  logic [NUM_M-1:0]        m_rready,
    output logic [ID_W-1:0]         arid,
    output logic [ADDR_W-1:0]       araddr,
    output logic [LEN_W-1:0]        arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arlock,
    output logic [3:0]              arcache,
    output logic [2:0]              arprot,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [ID_W-1:0]         rid,
    input  logic [DATA_W-1:0]       rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic                    burst_err
);
    localparam int IW = NUM_M > 1 ? $clog2(NUM_M) : 1;
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;
    state_e state_q, state_d;
    logic [IW-1:0] gnt_q, gnt_d, win;
    logic found;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [1:0] burst_q, burst_d;
    logic [LEN_W:0] beat_q, beat_d;
    logic err_q, err_d;
    logic unused_ok;
    assign unused_ok = ^{rid, rresp};
`ifdef AXI_RD_ARB_RR_EN
    logic [IW-1:0] rr_q, rr_d;
    // Descending scan so the requester closest to rr_q is the last (winning) assignment.
    always_comb begin
        int idx;
        idx = 0;
        win = '0;
        found = 1'b0;
        for (int k = NUM_M - 1; k >= 0; k--) begin
            idx = (int'(rr_q) + k) % NUM_M;
            if (m_arvalid[idx]) begin
                win = IW'(idx);
                found = 1'b1;
            end
        end
        rr_d = (state_q == IDLE && found) ? IW'((int'(win) + 1) % NUM_M) : rr_q;
    end
    always_ff @(posedge clk) rr_q <= rst ? '0 : rr_d;
`else
    always_comb begin
        win = '0;
        found = 1'b0;
        for (int i = NUM_M - 1; i >= 0; i--) begin
            if (m_arvalid[i]) begin
                win = IW'(i);
                found = 1'b1;
            end
        end
    end
`endif
    always_comb begin
        state_d = state_q;
        gnt_d = gnt_q;
        addr_d = addr_q;
        len_d = len_q;
        burst_d = burst_q;
        beat_d = beat_q;
        err_d = err_q;
        m_arready = '0;
        m_rvalid = '0;
        m_rlast = '0;
        rready = 1'b0;
        if (state_q == IDLE && found) begin
            m_arready = NUM_M'(1) << win;
            gnt_d = win;
            addr_d = m_araddr[win*ADDR_W +: ADDR_W];
            len_d = m_arlen[win*LEN_W +: LEN_W];
            burst_d = m_arburst[win*2 +: 2];
            beat_d = '0;
            state_d = ADDR;
        end
        if (state_q == ADDR && arready) state_d = DATA;
        if (state_q == DATA) begin
            rready = m_rready[gnt_q];
            m_rvalid = NUM_M'(rvalid) << gnt_q;
            m_rlast = NUM_M'(rlast) << gnt_q;
            if (rvalid && rready) begin
                beat_d = beat_q + 1'b1;
                state_d = rlast ? IDLE : DATA;
                // rlast must land exactly on beat arlen; flag either an early end or a missing rlast
                if (rlast ? beat_q != {1'b0, len_q} : beat_q == {1'b0, len_q}) err_d = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q <= '0;
            addr_q <= '0;
            len_q <= '0;
            burst_q <= '0;
            beat_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q <= gnt_d;
            addr_q <= addr_d;
            len_q <= len_d;
            burst_q <= burst_d;
            beat_q <= beat_d;
            err_q <= err_d;
        end
    end
    assign m_rdata = rdata;
    assign arid = ID_W'(gnt_q);
    assign araddr = addr_q;
    assign arlen = len_q;
    assign arburst = burst_q;
    assign arvalid = state_q == ADDR;
    assign arsize = 3'b010;
    assign arlock = 1'b0;
    assign arcache = 4'h0;
    assign arprot = 3'h0;
    assign burst_err = err_q;
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed reset/burst checks, then randomized traffic against a grant-order and burst scoreboard.
// Define AXI_RD_ARB_RR_EN here too to check the round-robin build.
module tb_axi_rd_arbiter;
    localparam int NM = 3, AW = 32, DW = 32, LW = 8, IDW = 4;
    typedef struct {
        int id;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [1:0] burst;
    } ar_t;
    logic clk = 1'b0, rst = 1'b1;
    logic [NM*AW-1:0] m_araddr;
    logic [NM*LW-1:0] m_arlen;
    logic [NM*2-1:0] m_arburst;
    logic [NM-1:0] m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
    logic [DW-1:0] m_rdata, rdata;
    logic [IDW-1:0] arid, rid;
    logic [AW-1:0] araddr;
    logic [LW-1:0] arlen;
    logic [2:0] arsize, arprot;
    logic [1:0] arburst, rresp;
    logic [3:0] arcache;
    logic arlock, arvalid, arready, rlast, rvalid, rready, burst_err;
    int errors = 0, checks = 0, beat_no = 0;
    logic mon_en = 1'b0, rand_go = 1'b0, dir_go = 1'b0, inject = 1'b0, in_data = 1'b0, exp_err = 1'b0;
    ar_t exp_ar[$];
    int exp_gnt[$];

    axi_rd_arbiter #(.NUM_M(NM), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .ID_W(IDW)) dut (
        .clk(clk), .rst(rst), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arburst(m_arburst),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rdata(m_rdata), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .arid(arid), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rvalid(rvalid), .rready(rready), .burst_err(burst_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Master-side stimulus: directed burst with a mid-burst reset, then randomized request rounds.
    initial begin
        int ptr, w, last, t;
        logic [NM-1:0] mask, pending, g;
        bit hit;
        m_araddr = '0;
        m_arlen = '0;
        m_arburst = '0;
        m_arvalid = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_arlen", arlen, 0);
        chk("rst_arid", arid, 0);
        chk("rst_arburst", arburst, 0);
        chk("rst_m_arready", m_arready, 0);
        chk("rst_m_rvalid", m_rvalid, 0);
        chk("rst_m_rlast", m_rlast, 0);
        chk("rst_rready", rready, 0);
        chk("rst_burst_err", burst_err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        dir_go = 1'b1;
        m_araddr[0 +: AW] = 32'h1FC0_0000;
        m_arlen[0 +: LW] = 8'd7;
        m_arburst[1:0] = 2'b01;
        m_arvalid = NM'(1);
        @(negedge clk);
        chk("d_grant", m_arready, 1);
        @(posedge clk); #1;
        m_arvalid = '0;
        @(negedge clk);
        chk("d_arvalid", arvalid, 1);
        chk("d_arid", arid, 0);
        chk("d_araddr", araddr, 32'h1FC0_0000);
        chk("d_arlen", arlen, 7);
        chk("d_arburst", arburst, 1);
        chk("d_arsize", arsize, 3'b010);
        hit = 0;
        for (int i = 0; i < 30 && !hit; i++) begin
            @(negedge clk);
            if (beat_no == 5) begin
                rst = 1'b1;
                hit = 1;
            end else if (beat_no > 0) begin
                chk("d_m_rvalid", m_rvalid, 1);
                chk("d_m_rlast", m_rlast, 0);
                chk("d_m_rdata", m_rdata, 32'hD000_0000 + beat_no);
                chk("d_rready", rready, 1);
            end
        end
        if (!hit) chk("d_beats", beat_no, 5);
        @(negedge clk);
        chk("mid_arvalid", arvalid, 0);
        chk("mid_m_rvalid", m_rvalid, 0);
        chk("mid_rready", rready, 0);
        chk("mid_arid", arid, 0);
        chk("mid_araddr", araddr, 0);
        chk("mid_burst_err", burst_err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;
        rand_go = 1'b1;
        ptr = 0;
        last = 0;
        for (int r = 0; r < 60; r++) begin
            inject = r >= 40;
            mask = NM'($urandom_range(1, (1 << NM) - 1));
            for (int i = 0; i < NM; i++) begin
                if (mask[i]) begin
                    m_araddr[i*AW +: AW] = $urandom;
                    m_arlen[i*LW +: LW] = ($urandom_range(0, 9) == 0) ? 8'd15 : LW'($urandom_range(0, 7));
                    m_arburst[i*2 +: 2] = 2'($urandom_range(0, 2));
                end
            end
            // All requesters stay up until served, so the grant order is a pure function of the mask.
            for (int k = 0; k < NM; k++) begin
`ifdef AXI_RD_ARB_RR_EN
                w = (ptr + k) % NM;
`else
                w = k;
`endif
                if (mask[w]) begin
                    exp_gnt.push_back(w);
                    exp_ar.push_back('{w, m_araddr[w*AW +: AW], m_arlen[w*LW +: LW], m_arburst[w*2 +: 2]});
                    last = w;
                end
            end
            ptr = (last + 1) % NM;
            m_arvalid = mask;
            pending = mask;
            t = 0;
            while (pending != 0 && t < 3000) begin
                @(negedge clk);
                g = m_arready & m_arvalid;
                @(posedge clk); #1;
                m_arvalid = m_arvalid & ~g;
                pending = pending & ~g;
                t++;
            end
            if (pending != 0) begin
                chk("grant_timeout", pending, 0);
                m_arvalid = '0;
                break;
            end
        end
        t = 0;
        while ((exp_ar.size() != 0 || in_data) && t < 5000) begin
            @(posedge clk);
            t++;
        end
        chk("drain", exp_ar.size() != 0 || in_data, 0);
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        m_rready = '1;
        forever begin
            @(posedge clk); #1;
            m_rready = rand_go ? NM'($urandom) : '1;
        end
    end

    // AXI slave: directed five-beat prefix for the reset test, then random arready/rvalid with optional rlast errors.
    initial begin
        int len, nb, b;
        arready = 1'b0;
        rvalid = 1'b0;
        rlast = 1'b0;
        rdata = '0;
        rid = '0;
        rresp = '0;
        while (!dir_go) @(posedge clk);
        #1 arready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (arvalid && arready) break;
        end
        @(posedge clk); #1;
        arready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            rvalid = 1'b1;
            rdata = 32'hD000_0000 + i;
            beat_no = i;
            @(posedge clk); #1;
        end
        rvalid = 1'b0;
        while (!rand_go) @(posedge clk);
        forever begin
            @(posedge clk); #1;
            arready = $urandom_range(0, 2) == 0;
            @(negedge clk);
            if (arvalid && arready) begin
                len = int'(arlen);
                nb = len + 1;
                if (inject && $urandom_range(0, 2) == 0)
                    nb = (len > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, len)) : len + 2;
                @(posedge clk); #1;
                arready = 1'b0;
                b = 0;
                while (b < nb) begin
                    rvalid = $urandom_range(0, 3) != 0;
                    rdata = $urandom;
                    rid = IDW'($urandom);
                    rresp = 2'($urandom);
                    rlast = b == nb - 1;
                    @(negedge clk);
                    if (rvalid && rready) b++;
                    @(posedge clk); #1;
                end
                rvalid = 1'b0;
                rlast = 1'b0;
            end
        end
    end

    // Monitor: pops expected grants and AR records, then checks R routing and burst_err against the beat count.
    initial begin
        int cur_id, cur_len, nbeats;
        logic arv_due, idle_due;
        logic [NM-1:0] oh;
        ar_t e;
        cur_id = 0;
        cur_len = 0;
        nbeats = 0;
        arv_due = 1'b0;
        idle_due = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                oh = NM'(1) << cur_id;
                if (in_data) begin
                    chk("rready", rready, m_rready[cur_id]);
                    chk("arready_busy", m_arready, 0);
                    if (rvalid) begin
                        chk("m_rvalid", m_rvalid, oh);
                        chk("m_rlast", m_rlast, rlast ? oh : '0);
                        chk("m_rdata", m_rdata, rdata);
                    end
                    if (rvalid && m_rready[cur_id]) begin
                        nbeats++;
                        if (rlast) begin
                            if (nbeats != cur_len + 1) exp_err = 1'b1;
                            in_data = 1'b0;
                            idle_due = 1'b1;
                        end
                    end
                end else begin
                    chk("rready_idle", rready, 0);
                    chk("m_rvalid_idle", m_rvalid, 0);
                    chk("burst_err", burst_err, exp_err);
                    if (idle_due && m_arvalid != 0) chk("turnaround", m_arready != 0, 1);
                    idle_due = 1'b0;
                    if (m_arready != 0) begin
                        if (exp_gnt.size() == 0) chk("grant_unexpected", m_arready, 0);
                        else chk("grant", m_arready, NM'(1) << exp_gnt.pop_front());
                    end
                end
                if (arv_due) chk("arvalid_lat", arvalid, 1);
                arv_due = (m_arready & m_arvalid) != 0;
                if (arvalid) begin
                    if (exp_ar.size() == 0) chk("ar_unexpected", arvalid, 0);
                    else begin
                        e = exp_ar[0];
                        chk("arid", arid, e.id);
                        chk("araddr", araddr, e.addr);
                        chk("arlen", arlen, e.len);
                        chk("arburst", arburst, e.burst);
                        if (arready) begin
                            chk("ar_const", {arsize, arlock, arcache, arprot}, {3'b010, 1'b0, 4'h0, 3'h0});
                            cur_id = e.id;
                            cur_len = int'(e.len);
                            nbeats = 0;
                            in_data = 1'b1;
                            void'(exp_ar.pop_front());
                        end
                    end
                end
            end
        end
    end
endmodule
